// File: rtl/gas_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gas_alarm_ctrl
// Brief   : Classifies ADC gas samples into none/warn/alarm with hysteresis and
//           debounce, then sequences the buzzer beat pattern with a timed mute.
// Rev     : 1.0
// ============================================================================
module gas_alarm_ctrl #(
    parameter logic [15:0] TH_WARN    = 16'd200,
    parameter logic [15:0] TH_ALARM   = 16'd1000,
    parameter logic [15:0] HYST       = 16'd20,
    parameter logic [3:0]  DEB_N      = 4'd4,
    parameter logic [23:0] BEAT_CYC   = 24'd8_250_000,
    parameter logic [15:0] MUTE_BEATS = 16'd240
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] ad_data,
    input  logic        ad_valid,
    input  logic        mute_key,
    output logic        beep_en,
    output logic        tone_sel,
    output logic [1:0]  level,
    output logic        muted
);

    localparam logic [15:0] c_WARN_REL  = TH_WARN - HYST;
    localparam logic [15:0] c_ALARM_REL = TH_ALARM - HYST;
    localparam logic [23:0] c_BEAT_LAST = BEAT_CYC - 24'd1;

    // State codes equal the level they sound for; MUTED takes the spare code.
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WARN  = 2'd1;
    localparam logic [1:0] c_ALARM = 2'd2;
    localparam logic [1:0] c_MUTED = 2'd3;

    logic [1:0]  r_level;
    logic [1:0]  r_pend;
    logic [3:0]  r_deb_cnt;
    logic [1:0]  r_state;
    logic [1:0]  r_phase;
    logic [23:0] r_beat_cnt;
    logic [15:0] r_mute_cnt;
    logic        r_beep_en;
    logic        r_tone_sel;
    logic        r_muted;

    logic [1:0]  w_target;
    logic [1:0]  w_level_nxt;
    logic [1:0]  w_state_nxt;
    logic        w_commit;
    logic        w_beat_tick;
    logic        w_mute_done;
    logic        w_restart;

    always_comb begin
        w_target = 2'd0;
        if (ad_data > TH_ALARM) begin
            w_target = 2'd2;
        end else if ((r_level == 2'd2) && (ad_data > c_ALARM_REL)) begin
            w_target = 2'd2;
        end else if (ad_data > TH_WARN) begin
            w_target = 2'd1;
        end else if ((r_level != 2'd0) && (ad_data > c_WARN_REL)) begin
            w_target = 2'd1;
        end
    end

    assign w_commit    = (r_deb_cnt == DEB_N);
    assign w_level_nxt = w_commit ? r_pend : r_level;
    assign w_beat_tick = (r_beat_cnt >= c_BEAT_LAST);
    assign w_mute_done = w_beat_tick && (r_mute_cnt <= 16'd1);

    // Level changes are resolved first; mute then overrides a sounding state.
    always_comb begin
        w_state_nxt = w_level_nxt;
        if (r_state == c_MUTED) begin
            if ((w_level_nxt != 2'd0) && (w_level_nxt <= r_level) && !w_mute_done) begin
                w_state_nxt = c_MUTED;
            end
        end else if (mute_key && (w_level_nxt != 2'd0)) begin
            w_state_nxt = c_MUTED;
        end
    end

    // Restarting on mute entry makes the silence span exactly MUTE_BEATS beats.
    assign w_restart = w_commit || ((r_state == c_MUTED) != (w_state_nxt == c_MUTED));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_level   <= 2'd0;
            r_pend    <= 2'd0;
            r_deb_cnt <= 4'd0;
        end else if (w_commit) begin
            r_level   <= r_pend;
            r_deb_cnt <= 4'd0;
        end else if (ad_valid) begin
            if (w_target == r_level) begin
                r_deb_cnt <= 4'd0;
            end else if (w_target == r_pend) begin
                r_deb_cnt <= r_deb_cnt + 4'd1;
            end else begin
                r_pend    <= w_target;
                r_deb_cnt <= 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_beat_cnt <= 24'd0;
            r_phase    <= 2'd0;
        end else if (w_restart) begin
            r_beat_cnt <= 24'd0;
            r_phase    <= 2'd0;
        end else if (w_beat_tick) begin
            r_beat_cnt <= 24'd0;
            r_phase    <= r_phase + 2'd1;
        end else begin
            r_beat_cnt <= r_beat_cnt + 24'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= c_IDLE;
            r_mute_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != c_MUTED) begin
                r_mute_cnt <= 16'd0;
            end else if (r_state != c_MUTED) begin
                r_mute_cnt <= MUTE_BEATS;
            end else if (w_beat_tick && (r_mute_cnt != 16'd0)) begin
                r_mute_cnt <= r_mute_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_beep_en  <= 1'b0;
            r_tone_sel <= 1'b0;
            r_muted    <= 1'b0;
        end else begin
            r_beep_en <= ((r_state == c_WARN) && (r_phase == 2'd0)) ||
                         ((r_state == c_ALARM) && !r_phase[0]);
            case (r_state)
                c_WARN:  r_tone_sel <= 1'b0;
                c_ALARM: r_tone_sel <= 1'b1;
                default: r_tone_sel <= r_level[1];
            endcase
            r_muted <= (r_state == c_MUTED);
        end
    end

    assign beep_en  = r_beep_en;
    assign tone_sel = r_tone_sel;
    assign level    = r_level;
    assign muted    = r_muted;

endmodule
`default_nettype wire

// File: tb/tb_gas_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_gas_alarm_ctrl
// Brief   : Scoreboard bench for gas_alarm_ctrl against a timeline-based model.
// Rev     : 1.0
// ============================================================================
module tb_gas_alarm_ctrl;

    localparam int BEAT = 10;
    localparam int MB   = 4;
    localparam int DEBN = 4;
    localparam int THW  = 200;
    localparam int THA  = 1000;
    localparam int HY   = 20;

    typedef enum int {S_IDLE, S_WARN, S_ALARM, S_MUTED} mstate_t;

    typedef struct packed {
        logic       beep;
        logic       tone;
        logic [1:0] lvl;
        logic       mut;
        int         cyc;
    } exp_t;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] ad_data   = 16'd0;
    logic        ad_valid  = 1'b0;
    logic        mute_key  = 1'b0;
    logic        beep_en;
    logic        tone_sel;
    logic [1:0]  level;
    logic        muted;

    gas_alarm_ctrl #(
        .TH_WARN   (16'd200),
        .TH_ALARM  (16'd1000),
        .HYST      (16'd20),
        .DEB_N     (4'd4),
        .BEAT_CYC  (24'd10),
        .MUTE_BEATS(16'd4)
    ) u_dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .ad_data  (ad_data),
        .ad_valid (ad_valid),
        .mute_key (mute_key),
        .beep_en  (beep_en),
        .tone_sel (tone_sel),
        .level    (level),
        .muted    (muted)
    );

    initial forever #5 sys_clk = ~sys_clk;

    exp_t    exp_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    bit      timeout_flag = 1'b0;

    // Reference model: levels from the classification rules, beat pattern
    // from elapsed cycles since the last pattern restart.
    int      m_t, m_L, m_newL, m_pstart, m_rem, m_ph, m_tgt, m_cval, m_v;
    bit      m_cdue, m_chg, m_restart;
    mstate_t m_st, m_ns;
    int      m_hist[$];
    exp_t    m_e;

    function automatic int classify(input int v, input int lv);
        if (v > THA) return 2;
        if (lv == 2 && v > THA - HY) return 2;
        if (v > THW) return 1;
        if (lv >= 1 && v > THW - HY) return 1;
        return 0;
    endfunction

    function automatic mstate_t for_level(input int lv);
        if (lv == 2) return S_ALARM;
        if (lv == 1) return S_WARN;
        return S_IDLE;
    endfunction

    initial begin
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                m_t = 0; m_L = 0; m_st = S_IDLE; m_pstart = 0; m_rem = 0;
                m_cdue = 1'b0; m_cval = 0;
                m_hist.delete();
                m_e = '0;
                exp_q.delete();
                exp_q.push_back(m_e);
            end else begin
                m_t = m_t + 1;
                m_ph = ((m_t - 1 - m_pstart) / BEAT) % 4;
                m_e = '0;
                m_e.cyc = m_t;
                if (m_st == S_WARN) begin
                    m_e.beep = (m_ph == 0);
                    m_e.tone = 1'b0;
                end else if (m_st == S_ALARM) begin
                    m_e.beep = (m_ph % 2 == 0);
                    m_e.tone = 1'b1;
                end else begin
                    m_e.beep = 1'b0;
                    m_e.tone = (m_L == 2);
                end
                m_e.mut = (m_st == S_MUTED);

                m_newL = m_L;
                m_chg  = 1'b0;
                if (m_cdue) begin
                    m_newL = m_cval;
                    m_cdue = 1'b0;
                    m_chg  = 1'b1;
                end else if (ad_valid) begin
                    m_v   = int'(ad_data);
                    m_tgt = classify(m_v, m_L);
                    if (m_tgt == m_L) begin
                        m_hist.delete();
                    end else begin
                        if (m_hist.size() > 0 && m_hist[$] != m_tgt) m_hist.delete();
                        m_hist.push_back(m_tgt);
                        if (m_hist.size() == DEBN) begin
                            m_cdue = 1'b1;
                            m_cval = m_tgt;
                            m_hist.delete();
                        end
                    end
                end
                m_e.lvl = 2'(m_newL);
                exp_q.push_back(m_e);

                if (m_st == S_MUTED) begin
                    if (m_newL == 0)                         m_ns = S_IDLE;
                    else if (m_newL > m_L)                   m_ns = S_ALARM;
                    else if (m_t == m_pstart + m_rem * BEAT) m_ns = for_level(m_newL);
                    else                                     m_ns = S_MUTED;
                end else begin
                    m_ns = for_level(m_newL);
                    if (mute_key && m_ns != S_IDLE) m_ns = S_MUTED;
                end
                m_restart = m_chg || ((m_st == S_MUTED) != (m_ns == S_MUTED));
                if (m_ns == S_MUTED && m_st != S_MUTED) m_rem = MB;
                else if (m_ns == S_MUTED && m_restart)  m_rem = m_rem - (m_t - m_pstart) / BEAT;
                if (m_restart) m_pstart = m_t;
                m_st = m_ns;
                m_L  = m_newL;
            end
        end
    end

    exp_t c_e;
    bit   to_seen = 1'b0;

    initial begin
        forever begin
            @(negedge sys_clk or negedge sys_rst_n);
            if ($time != 0) begin
                if (sys_clk) begin
                    #1;
                    n_tests++;
                    if ({beep_en, tone_sel, level, muted} !== 5'b0) begin
                        n_fail++;
                        $display("FAIL async_reset: got beep=%b tone=%b level=%0d muted=%b, required all 0",
                                 beep_en, tone_sel, level, muted);
                    end
                end else begin
                    if (timeout_flag && !to_seen) begin
                        to_seen = 1'b1;
                        n_tests++;
                        n_fail++;
                        $display("FAIL wait_beep: beep_en not seen within bound, required 1");
                    end
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard: no expected entry, got level=%0d", level);
                    end else begin
                        c_e = exp_q.pop_front();
                        if (beep_en !== c_e.beep || tone_sel !== c_e.tone ||
                            level !== c_e.lvl || muted !== c_e.mut) begin
                            n_fail++;
                            $display("FAIL outputs cyc=%0d: got beep=%b tone=%b level=%0d muted=%b, required beep=%b tone=%b level=%0d muted=%b",
                                     c_e.cyc, beep_en, tone_sel, level, muted,
                                     c_e.beep, c_e.tone, c_e.lvl, c_e.mut);
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] v, input int gap, input int mk_at);
        for (int c = 0; c < gap; c++) begin
            ad_valid = (c == 0);
            ad_data  = v;
            mute_key = (c == mk_at);
            @(posedge sys_clk);
            #1;
        end
        ad_valid = 1'b0;
        mute_key = 1'b0;
    endtask

    task automatic send_n(input logic [15:0] v, input int n);
        for (int k = 0; k < n; k++) send(v, 5, -1);
    endtask

    task automatic pulse_mute();
        mute_key = 1'b1;
        @(posedge sys_clk);
        #1;
        mute_key = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    int unsigned vals[10] = '{0, 180, 181, 200, 201, 980, 981, 1000, 1001, 65535};
    bit          found;

    initial begin
        idle(3);
        release_reset();
        idle(5);

        send_n(16'd300, 3); send(16'd100, 5, -1); send_n(16'd300, 3);
        send(16'd100, 5, -1);
        idle(10);

        send_n(16'd300, 4);
        idle(90);

        send_n(16'd190, 4);
        idle(10);
        send_n(16'd180, 4);
        idle(20);

        send_n(16'd1200, 4);
        idle(50);
        send_n(16'd990, 4);
        send_n(16'd970, 4);
        idle(30);

        pulse_mute();
        idle(70);
        pulse_mute();
        idle(5);
        send_n(16'd1200, 4);
        idle(40);

        for (int i = 0; i < 80; i++) begin
            int unsigned pick;
            int unsigned reps;
            logic [15:0] v;
            pick = $urandom_range(0, 13);
            v    = (pick < 10) ? 16'(vals[pick]) : 16'($urandom_range(0, 1300));
            reps = $urandom_range(1, 6);
            for (int r = 0; r < int'(reps); r++) begin
                int gap;
                gap = int'($urandom_range(2, 7));
                send(v, gap, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, gap - 1)) : -1);
            end
        end
        idle(20);

        send_n(16'd1200, 4);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge sys_clk);
            #2;
            found = beep_en;
        end
        if (!found) timeout_flag = 1'b1;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        release_reset();
        idle(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
